// File: rtl/wrr_pkg.sv
// ---------------------------------------------------------------------------
// wrr_pkg
// Shared definitions for the weighted round-robin VC scheduler:
//   - virtual-channel identifiers VCHANEL0..VCHANEL3
//   - scheduler state encoding (IDLE / SERVE)
//   - default data and credit widths
// ---------------------------------------------------------------------------
package wrr_pkg;

   localparam int NUM_VC       = 4;
   localparam int DEF_DATA_W   = 4;
   localparam int DEF_CREDIT_W = 4;

   typedef enum logic [1:0] {
      VCHANEL0 = 2'b00,
      VCHANEL1 = 2'b01,
      VCHANEL2 = 2'b10,
      VCHANEL3 = 2'b11
   } vc_id_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_e;

endpackage

// File: rtl/wrr_next_vc.sv
// ---------------------------------------------------------------------------
// wrr_next_vc
// Combinational circular priority finder. Starting at 'start' and wrapping
// around, returns the first channel whose bit in 'mask' is set. The channel
// just before 'start' is therefore examined last.
// Ports:
//   start  in  2  first channel id to examine
//   mask   in  4  eligibility mask, bit i = channel i eligible
//   found  out 1  at least one eligible channel
//   id     out 2  id of the first eligible channel (0 when none found)
// ---------------------------------------------------------------------------
module wrr_next_vc
   import wrr_pkg::*;
(
   input  logic [1:0]        start,
   input  logic [NUM_VC-1:0] mask,
   output logic              found,
   output logic [1:0]        id
);

   // rot[k] = eligibility of the channel k positions after 'start'
   logic [NUM_VC-1:0] rot;
   logic [1:0]        offset;

   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_rot
         logic [1:0] idx;
         assign idx     = start + 2'(gi);
         assign rot[gi] = mask[idx];
      end
   endgenerate

   // Lowest set position of the rotated mask wins.
   always_comb begin
      offset = 2'd0;
      for (int k = NUM_VC - 1; k >= 0; k--) begin
         if (rot[k]) begin
            offset = 2'(k);
         end
      end
   end

   assign found = |rot;
   assign id    = found ? (start + offset) : 2'd0;

endmodule

// File: rtl/wrr_vc_scheduler.sv
// ---------------------------------------------------------------------------
// wrr_vc_scheduler
// Weighted round-robin scheduler draining four show-ahead VC FIFOs onto one
// egress. Each granted channel gets up to WEIGHTn pops per turn; a channel
// that runs empty forfeits the rest of its turn (one bubble cycle).
//
// Optional feature (macro WRR_WEIGHT_CFG_EN): run-time loadable weights via
// cfg_load / cfg_weight0..3. Without the macro the weights are the WEIGHTn
// parameters.
//
// Ports:
//   clk                  in   clock, rising edge
//   rst                  in   synchronous active-high reset (beats enb)
//   enb                  in   enable; low freezes all state, valid_out=0
//   empty_vchanel0..3    in   VC FIFO empty flags
//   out_vchanel0..3      in   VC FIFO head data (show-ahead)
//   full_egress          in   egress backpressure, blocks pops
//   cfg_load             in   (WRR_WEIGHT_CFG_EN) load weight registers
//   cfg_weight0..3       in   (WRR_WEIGHT_CFG_EN) new weights
//   pop_vchanel0..3      out  combinational pop strobes, one-hot or zero
//   out_wgthd_rndrobin   out  registered egress data
//   valid_out            out  egress data valid, one cycle per popped word
//   arbiter              out  registered id of the granted VC
// ---------------------------------------------------------------------------
module wrr_vc_scheduler
   import wrr_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CREDIT_W = DEF_CREDIT_W,
   parameter int WEIGHT0  = 4,
   parameter int WEIGHT1  = 3,
   parameter int WEIGHT2  = 2,
   parameter int WEIGHT3  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic              empty_vchanel0,
   input  logic              empty_vchanel1,
   input  logic              empty_vchanel2,
   input  logic              empty_vchanel3,
   input  logic [DATA_W-1:0] out_vchanel0,
   input  logic [DATA_W-1:0] out_vchanel1,
   input  logic [DATA_W-1:0] out_vchanel2,
   input  logic [DATA_W-1:0] out_vchanel3,
   input  logic              full_egress,
`ifdef WRR_WEIGHT_CFG_EN
   input  logic                cfg_load,
   input  logic [CREDIT_W-1:0] cfg_weight0,
   input  logic [CREDIT_W-1:0] cfg_weight1,
   input  logic [CREDIT_W-1:0] cfg_weight2,
   input  logic [CREDIT_W-1:0] cfg_weight3,
`endif
   output logic              pop_vchanel0,
   output logic              pop_vchanel1,
   output logic              pop_vchanel2,
   output logic              pop_vchanel3,
   output logic [DATA_W-1:0] out_wgthd_rndrobin,
   output logic              valid_out,
   output logic [1:0]        arbiter
);

   localparam int WEIGHT_INIT [NUM_VC] = '{WEIGHT0, WEIGHT1, WEIGHT2, WEIGHT3};

   logic [NUM_VC-1:0]   empty_vec;
   logic [NUM_VC-1:0]   elig_vec;
   logic [NUM_VC-1:0]   pop_vec;
   logic [DATA_W-1:0]   head_arr   [NUM_VC];
   logic [CREDIT_W-1:0] weight_arr [NUM_VC];

   state_e              state_reg;
   logic [1:0]          arbiter_reg;
   logic [CREDIT_W-1:0] credit_reg;
   logic [DATA_W-1:0]   data_reg;
   logic                valid_reg;

   logic                serve_pop;
   logic                turn_over;
   logic                found;
   logic [1:0]          next_id;

   assign empty_vec   = {empty_vchanel3, empty_vchanel2, empty_vchanel1, empty_vchanel0};
   assign head_arr[0] = out_vchanel0;
   assign head_arr[1] = out_vchanel1;
   assign head_arr[2] = out_vchanel2;
   assign head_arr[3] = out_vchanel3;

   // ---------------------------------------------------------------- weights
`ifdef WRR_WEIGHT_CFG_EN
   logic [CREDIT_W-1:0] cfg_arr    [NUM_VC];
   logic [CREDIT_W-1:0] weight_reg [NUM_VC];

   assign cfg_arr[0] = cfg_weight0;
   assign cfg_arr[1] = cfg_weight1;
   assign cfg_arr[2] = cfg_weight2;
   assign cfg_arr[3] = cfg_weight3;

   // New weights only take effect when a credit is reloaded; the running
   // turn keeps counting down the credit it already holds.
   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_weight_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               weight_reg[gi] <= CREDIT_W'(WEIGHT_INIT[gi]);
            end else if (cfg_load) begin
               weight_reg[gi] <= cfg_arr[gi];
            end
         end
         assign weight_arr[gi] = weight_reg[gi];
      end
   endgenerate
`else
   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_weight_const
         assign weight_arr[gi] = CREDIT_W'(WEIGHT_INIT[gi]);
      end
   endgenerate
`endif

   // A channel takes part in the search only if it has data and a non-zero
   // weight; weight 0 disables it permanently.
   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_elig
         assign elig_vec[gi] = !empty_vec[gi] && (weight_arr[gi] != '0);
      end
   endgenerate

   // Both the IDLE search and the end-of-turn search start one past the
   // current grant, so the current channel is considered last.
   wrr_next_vc u_next_vc (
      .start (arbiter_reg + 2'd1),
      .mask  (elig_vec),
      .found (found),
      .id    (next_id)
   );

   // ------------------------------------------------------------------ pops
   // Gated by !rst so a pop in flight during reset never reaches a FIFO.
   assign serve_pop = !rst && enb && (state_reg == SERVE) && !full_egress &&
                      !empty_vec[arbiter_reg] && (credit_reg != '0);

   assign pop_vec = serve_pop ? (NUM_VC'(1) << arbiter_reg) : '0;

   assign pop_vchanel0 = pop_vec[0];
   assign pop_vchanel1 = pop_vec[1];
   assign pop_vchanel2 = pop_vec[2];
   assign pop_vchanel3 = pop_vec[3];

   // Turn ends on the last credited pop, or when the granted channel is
   // empty (remaining credit forfeited). The empty case is independent of
   // full_egress, so an empty channel is switched away even under
   // backpressure.
   assign turn_over = serve_pop ? (credit_reg == CREDIT_W'(1))
                                : (empty_vec[arbiter_reg] || (credit_reg == '0));

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         arbiter_reg <= VCHANEL3;
         credit_reg  <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
      end else if (enb) begin
         valid_reg <= serve_pop;
         if (serve_pop) begin
            data_reg <= head_arr[arbiter_reg];
         end
         case (state_reg)
            IDLE: begin
               if (found) begin
                  state_reg   <= SERVE;
                  arbiter_reg <= next_id;
                  credit_reg  <= weight_arr[next_id];
               end
            end
            SERVE: begin
               if (turn_over) begin
                  if (found) begin
                     arbiter_reg <= next_id;
                     credit_reg  <= weight_arr[next_id];
                  end else begin
                     state_reg  <= IDLE;
                     credit_reg <= '0;
                  end
               end else if (serve_pop) begin
                  credit_reg <= credit_reg - CREDIT_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end else begin
         valid_reg <= 1'b0;
      end
   end

   assign out_wgthd_rndrobin = data_reg;
   assign valid_out          = valid_reg;
   assign arbiter            = arbiter_reg;

endmodule

// File: tb/tb_wrr_vc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wrr_vc_scheduler
// Self-checking bench for wrr_vc_scheduler (default build, weights 4/3/2/1).
// Directed scenarios with hand-derived expectations, followed by a random
// run checked against a queue-based behavioural model of the scheduler.
// ---------------------------------------------------------------------------
module tb_wrr_vc_scheduler;

   localparam int DW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enb;
   logic          full_egress;
   logic [3:0]    empty_v;
   logic [DW-1:0] head_v [4];
   logic [3:0]    pop_v;
   logic [DW-1:0] dout;
   logic          valid;
   logic [1:0]    arb;

   int checks   = 0;
   int failures = 0;
   int wgt [4]  = '{4, 3, 2, 1};

   always #5 clk = ~clk;

   wrr_vc_scheduler #(
      .DATA_W   (DW),
      .CREDIT_W (CW),
      .WEIGHT0  (4),
      .WEIGHT1  (3),
      .WEIGHT2  (2),
      .WEIGHT3  (1)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .enb                (enb),
      .empty_vchanel0     (empty_v[0]),
      .empty_vchanel1     (empty_v[1]),
      .empty_vchanel2     (empty_v[2]),
      .empty_vchanel3     (empty_v[3]),
      .out_vchanel0       (head_v[0]),
      .out_vchanel1       (head_v[1]),
      .out_vchanel2       (head_v[2]),
      .out_vchanel3       (head_v[3]),
      .full_egress        (full_egress),
      .pop_vchanel0       (pop_v[0]),
      .pop_vchanel1       (pop_v[1]),
      .pop_vchanel2       (pop_v[2]),
      .pop_vchanel3       (pop_v[3]),
      .out_wgthd_rndrobin (dout),
      .valid_out          (valid),
      .arbiter            (arb)
   );

   // Leaves the bench at a falling edge with rst low and the DUT freshly reset.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      enb = 1'b1;
      full_egress = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      empty_v = 4'b0000;
      enb = 1'b1;
      full_egress = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (pop_v !== 4'b0000) begin failures++; $display("FAIL reset_pop got=%b exp=0000", pop_v); end
      checks++; if (arb !== 2'd3) begin failures++; $display("FAIL reset_arbiter got=%0d exp=3", arb); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (dout !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", dout); end
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (arb !== 2'd0 || pop_v !== 4'b0001) begin
         failures++; $display("FAIL reset_first_grant arb=%0d pop=%b exp arb=0 pop=0001", arb, pop_v);
      end
      $display("test_reset: done");
   endtask

   task automatic test_weighted_sequence();
      int seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
      int e;
      int p;
      logic [3:0] exp_vec;
      head_v[0] = 4'hA; head_v[1] = 4'h5; head_v[2] = 4'h3; head_v[3] = 4'hC;
      empty_v = 4'b0000;
      do_reset();
      #1;
      checks++; if (pop_v !== 4'b0000) begin failures++; $display("FAIL seq_idle_pop got=%b exp=0000", pop_v); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         e = seq[i % 10];
         exp_vec = 4'b0001 << e;
         checks++; if (arb !== 2'(e) || pop_v !== exp_vec) begin
            failures++; $display("FAIL seq_grant i=%0d arb=%0d pop=%b exp arb=%0d pop=%b", i, arb, pop_v, e, exp_vec);
         end
         if (i > 0) begin
            p = seq[(i - 1) % 10];
            checks++; if (valid !== 1'b1 || dout !== head_v[p]) begin
               failures++; $display("FAIL latency_data i=%0d valid=%b data=%h exp valid=1 data=%h", i, valid, dout, head_v[p]);
            end
         end
         $display("seq cycle %0d: arb=%0d pop=%b valid=%b data=%h", i, arb, pop_v, valid, dout);
      end
   endtask

   task automatic test_empty_bubble();
      empty_v = 4'b0000;
      do_reset();
      repeat (5) @(negedge clk);
      #1;
      checks++; if (arb !== 2'd1 || pop_v !== 4'b0010) begin
         failures++; $display("FAIL bubble_vc1_first arb=%0d pop=%b exp arb=1 pop=0010", arb, pop_v);
      end
      @(negedge clk);
      empty_v[1] = 1'b1;
      #1;
      checks++; if (pop_v !== 4'b0000 || arb !== 2'd1) begin
         failures++; $display("FAIL bubble_cycle arb=%0d pop=%b exp arb=1 pop=0000", arb, pop_v);
      end
      @(negedge clk);
      #1;
      checks++; if (arb !== 2'd2 || pop_v !== 4'b0100 || valid !== 1'b0) begin
         failures++; $display("FAIL bubble_switch arb=%0d pop=%b valid=%b exp arb=2 pop=0100 valid=0", arb, pop_v, valid);
      end
      empty_v = 4'b0000;
      $display("test_empty_bubble: done");
   endtask

   task automatic test_full_hold();
      empty_v = 4'b0000;
      do_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         full_egress = 1'b1;
         #1;
         checks++; if (pop_v !== 4'b0000 || arb !== 2'd0) begin
            failures++; $display("FAIL full_hold i=%0d arb=%0d pop=%b exp arb=0 pop=0000", i, arb, pop_v);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         full_egress = 1'b0;
         #1;
         checks++; if ((i < 2 && (arb !== 2'd0 || pop_v !== 4'b0001)) || (i == 2 && (arb !== 2'd1 || pop_v !== 4'b0010))) begin
            failures++; $display("FAIL full_resume i=%0d arb=%0d pop=%b", i, arb, pop_v);
         end
      end
      $display("test_full_hold: done");
   endtask

   task automatic test_vc3_only();
      empty_v = 4'b0111;
      do_reset();
      #1;
      checks++; if (pop_v !== 4'b0000) begin failures++; $display("FAIL vc3_idle got=%b exp=0000", pop_v); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++; if (arb !== 2'd3 || pop_v !== 4'b1000) begin
            failures++; $display("FAIL vc3_reselect i=%0d arb=%0d pop=%b exp arb=3 pop=1000", i, arb, pop_v);
         end
      end
      @(negedge clk);
      empty_v = 4'b1111;
      #1;
      checks++; if (pop_v !== 4'b0000 || valid !== 1'b1) begin
         failures++; $display("FAIL vc3_empty pop=%b valid=%b exp pop=0000 valid=1", pop_v, valid);
      end
      @(negedge clk);
      #1;
      checks++; if (pop_v !== 4'b0000 || valid !== 1'b0) begin
         failures++; $display("FAIL vc3_idle_valid pop=%b valid=%b exp pop=0000 valid=0", pop_v, valid);
      end
      @(negedge clk);
      empty_v = 4'b0111;
      #1;
      checks++; if (pop_v !== 4'b0000) begin failures++; $display("FAIL vc3_idle_again pop=%b exp=0000", pop_v); end
      @(negedge clk);
      #1;
      checks++; if (pop_v !== 4'b1000) begin failures++; $display("FAIL vc3_regrant pop=%b exp=1000", pop_v); end
      $display("test_vc3_only: done");
   endtask

   task automatic test_reset_mid_and_enb();
      empty_v = 4'b0000;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (pop_v !== 4'b0000) begin failures++; $display("FAIL midreset_pop got=%b exp=0000", pop_v); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (arb !== 2'd3 || valid !== 1'b0 || pop_v !== 4'b0000) begin
         failures++; $display("FAIL midreset_after arb=%0d valid=%b pop=%b exp arb=3 valid=0 pop=0000", arb, valid, pop_v);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         enb = 1'b0;
         #1;
         checks++; if (pop_v !== 4'b0000 || arb !== 2'd0 || (i > 0 && valid !== 1'b0)) begin
            failures++; $display("FAIL enb_freeze i=%0d arb=%0d pop=%b valid=%b", i, arb, pop_v, valid);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         enb = 1'b1;
         #1;
         checks++; if ((i < 2 && (arb !== 2'd0 || pop_v !== 4'b0001)) || (i == 2 && (arb !== 2'd1 || pop_v !== 4'b0010))) begin
            failures++; $display("FAIL enb_resume i=%0d arb=%0d pop=%b", i, arb, pop_v);
         end
      end
      $display("test_reset_mid_and_enb: done");
   endtask

   // ---------------------------------------------------- behavioural model
   logic [DW-1:0] q [4][$];
   bit            m_serving;
   int            m_arb;
   int            m_left;
   bit            m_valid;
   logic [DW-1:0] m_data;

   // First channel after m_arb (wrapping, m_arb itself last) that has data
   // and a non-zero weight; -1 when there is none.
   function automatic int find_next();
      int v;
      for (int k = 1; k <= 4; k++) begin
         v = (m_arb + k) % 4;
         if (q[v].size() > 0 && wgt[v] > 0) return v;
      end
      return -1;
   endfunction

   task automatic model_new_turn();
      int v;
      v = find_next();
      if (v >= 0) begin
         m_serving = 1'b1;
         m_arb = v;
         m_left = wgt[v];
      end else begin
         m_serving = 1'b0;
         m_left = 0;
      end
   endtask

   task automatic test_random();
      bit         do_pop;
      int         pop_vc;
      logic [3:0] exp_vec;
      for (int v = 0; v < 4; v++) q[v].delete();
      empty_v = 4'b1111;
      do_reset();
      m_serving = 1'b0; m_arb = 3; m_left = 0; m_valid = 1'b0; m_data = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc > 0) @(negedge clk);
         for (int v = 0; v < 4; v++) begin
            if (q[v].size() < 6 && $urandom_range(0, 2) == 0) q[v].push_back(DW'($urandom));
         end
         rst = ($urandom_range(0, 79) == 0);
         enb = ($urandom_range(0, 7) != 0);
         full_egress = ($urandom_range(0, 3) == 0);
         for (int v = 0; v < 4; v++) begin
            empty_v[v] = (q[v].size() == 0);
            head_v[v] = (q[v].size() == 0) ? DW'($urandom) : q[v][0];
         end
         #1;
         do_pop = !rst && enb && m_serving && !full_egress && q[m_arb].size() > 0 && m_left > 0;
         pop_vc = m_arb;
         exp_vec = do_pop ? (4'b0001 << pop_vc) : 4'b0000;
         checks++; if (pop_v !== exp_vec) begin
            failures++; $display("FAIL rnd_pop cyc=%0d got=%b exp=%b", cyc, pop_v, exp_vec);
         end
         checks++; if (arb !== 2'(m_arb)) begin
            failures++; $display("FAIL rnd_arbiter cyc=%0d got=%0d exp=%0d", cyc, arb, m_arb);
         end
         checks++; if (valid !== m_valid) begin
            failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid, m_valid);
         end
         checks++; if (dout !== m_data) begin
            failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, dout, m_data);
         end
         $display("rnd cyc %0d: rst=%b enb=%b full=%b empty=%b pop=%b arb=%0d valid=%b data=%h",
                  cyc, rst, enb, full_egress, empty_v, pop_v, arb, valid, dout);
         // Next state, decided on this cycle's (pre-pop) FIFO contents.
         if (rst) begin
            m_serving = 1'b0; m_arb = 3; m_left = 0; m_valid = 1'b0; m_data = '0;
         end else if (!enb) begin
            m_valid = 1'b0;
         end else begin
            m_valid = do_pop;
            if (do_pop) m_data = q[pop_vc][0];
            if (!m_serving) model_new_turn();
            else if (do_pop) begin
               if (m_left == 1) model_new_turn();
               else m_left--;
            end else if (q[m_arb].size() == 0) model_new_turn();
         end
         if (do_pop) void'(q[pop_vc].pop_front());
      end
      @(negedge clk);
      rst = 1'b0;
      enb = 1'b1;
      full_egress = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      enb = 1'b1;
      full_egress = 1'b0;
      empty_v = 4'b1111;
      for (int v = 0; v < 4; v++) head_v[v] = '0;
      test_reset();
      test_weighted_sequence();
      test_empty_bubble();
      test_full_hold();
      test_vc3_only();
      test_reset_mid_and_enb();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
